// File: rtl/quadrilatero_decode_queue_pkg.sv
// Shared types and encodings for the quadrilatero matrix decode front end.
package quadrilatero_pkg;

  localparam logic [6:0] MATRIX_OPCODE = 7'b0101011;
  localparam logic [4:0] F5_MLD        = 5'b00000;
  localparam logic [4:0] F5_MST        = 5'b00001;
  localparam logic [4:0] F5_MMAC_F     = 5'b00010;
  localparam logic [4:0] F5_MMAC_I     = 5'b11110;
  localparam logic [4:0] F5_MISC       = 5'b11111;
  localparam logic [1:0] MISC_MZERO    = 2'b00;
  localparam logic [1:0] MISC_MCFG     = 2'b11;

  // Micro-op fields are sized for the widest supported configuration.
  localparam int UOP_XLEN  = 32;
  localparam int UOP_REG_W = 5;
  localparam int UOP_DIM_W = 8;

  typedef enum logic [2:0] {
    UOP_MLD    = 3'd0,
    UOP_MST    = 3'd1,
    UOP_MMAC_F = 3'd2,
    UOP_MMAC_I = 3'd3,
    UOP_MZERO  = 3'd4
  } uop_class_e;

  typedef enum logic [1:0] {
    EW_B = 2'd0,
    EW_H = 2'd1,
    EW_W = 2'd2,
    EW_D = 2'd3
  } elem_width_e;

  typedef struct packed {
    uop_class_e           cls;
    elem_width_e          ew;
    logic [UOP_REG_W-1:0] md;
    logic [UOP_REG_W-1:0] ms1;
    logic [UOP_REG_W-1:0] ms2;
    logic [UOP_XLEN-1:0]  rs1;
    logic [UOP_XLEN-1:0]  rs2;
    logic [UOP_DIM_W-1:0] m;
    logic [UOP_DIM_W-1:0] n;
    logic [UOP_DIM_W-1:0] k;
  } uop_t;

  // A zero dimension is meaningless, so it is promoted to 1.
  function automatic logic [7:0] clamp_dim(input logic [7:0] v, input logic [7:0] max_v);
    logic [7:0] r;
    if (v == 8'd0) begin
      r = 8'd1;
    end else if (v > max_v) begin
      r = max_v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/quadrilatero_decode_queue_fifo.sv
// Generic type-parametrised FIFO with synchronous flush; DEPTH need not be a power of 2.
module quadrilatero_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic valid,
  output logic empty,
  output logic full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Flush suppresses both push and pop in the same cycle.
  always_comb begin
    do_push_s = push && !flush && (count_r != CNT_W'(DEPTH));
    do_pop_s  = pop && !flush && (count_r != '0);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= bump(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= bump(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = (count_r != '0);
  assign empty = (count_r == '0);
  assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/quadrilatero_decode_queue.sv
// Matrix instruction decode, local MCFG handling and micro-op queue.
// Optional perf counters: define QUADRILATERO_DECODE_PERF_EN.
module quadrilatero_decode_queue
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS    = 8,
  parameter int DEPTH     = 4,
  parameter int XLEN      = 32,
  parameter int MAX_DIM   = 4,
  parameter int ENABLE_64 = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  input  logic [31:0]                       issue_instr_i,
  input  logic [XLEN-1:0]                   issue_rs1_i,
  input  logic [XLEN-1:0]                   issue_rs2_i,
  output logic                              issue_accept_o,
  input  logic                              flush_i,
  output logic                              uop_valid_o,
  input  logic                              uop_ready_i,
  output uop_t                              uop_o,
  output logic [3*$clog2(MAX_DIM+1)-1:0]    cfg_o,
  output logic                              empty_o
`ifdef QUADRILATERO_DECODE_PERF_EN
  ,
  output logic [31:0]                       perf_accepted_o,
  output logic [31:0]                       perf_illegal_o,
  output logic [31:0]                       perf_stall_o
`endif
);

  localparam int         REG_W    = $clog2(N_REGS);
  localparam int         DIM_W    = $clog2(MAX_DIM + 1);
  localparam logic [5:0] N_REGS_L = 6'(N_REGS);

  logic             class_ok_s, ew_ok_s, regs_ok_s, legal_s, is_mcfg_s;
  logic             ready_s, push_s, mcfg_fire_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [2:0]       ew_field_s;
  uop_class_e       cls_s;
  uop_t             uop_in_s;
  logic [DIM_W-1:0] m_r, n_r, k_r;

  // Instruction classification and legality.
  always_comb begin
    cls_s      = UOP_MLD;
    class_ok_s = 1'b0;
    is_mcfg_s  = 1'b0;
    ew_field_s = issue_instr_i[14:12];
    case (issue_instr_i[31:27])
      F5_MLD:    begin cls_s = UOP_MLD;    class_ok_s = 1'b1; end
      F5_MST:    begin cls_s = UOP_MST;    class_ok_s = 1'b1; end
      F5_MMAC_F: begin cls_s = UOP_MMAC_F; class_ok_s = 1'b1; end
      F5_MMAC_I: begin cls_s = UOP_MMAC_I; class_ok_s = 1'b1; end
      F5_MISC: begin
        if (issue_instr_i[26:25] == MISC_MZERO) begin
          cls_s      = UOP_MZERO;
          class_ok_s = 1'b1;
        end else if (issue_instr_i[26:25] == MISC_MCFG) begin
          is_mcfg_s  = 1'b1;
          class_ok_s = 1'b1;
        end else begin
          class_ok_s = 1'b0;
        end
      end
      default: class_ok_s = 1'b0;
    endcase
    ew_ok_s   = (ew_field_s < 3'd3) || ((ew_field_s == 3'd3) && (ENABLE_64 != 0));
    regs_ok_s = is_mcfg_s ||
                (({1'b0, issue_instr_i[11:7]}  < N_REGS_L) &&
                 ({1'b0, issue_instr_i[19:15]} < N_REGS_L) &&
                 ({1'b0, issue_instr_i[24:20]} < N_REGS_L));
    legal_s   = (issue_instr_i[6:0] == MATRIX_OPCODE) && class_ok_s && ew_ok_s && regs_ok_s;
  end

  // Handshake: illegal ops are consumed at once, MCFG waits for an empty queue.
  always_comb begin
    ready_s = 1'b0;
    if (issue_valid_i && !flush_i) begin
      if (!legal_s) begin
        ready_s = 1'b1;
      end else if (is_mcfg_s) begin
        ready_s = fifo_empty_s;
      end else begin
        ready_s = !fifo_full_s;
      end
    end else begin
      ready_s = 1'b0;
    end
    push_s      = ready_s && legal_s && !is_mcfg_s;
    mcfg_fire_s = ready_s && legal_s && is_mcfg_s;
  end

  always_comb begin
    uop_in_s     = '0;
    uop_in_s.cls = cls_s;
    uop_in_s.ew  = elem_width_e'(ew_field_s[1:0]);
    uop_in_s.md  = UOP_REG_W'(issue_instr_i[7+:REG_W]);
    uop_in_s.ms1 = UOP_REG_W'(issue_instr_i[15+:REG_W]);
    uop_in_s.ms2 = UOP_REG_W'(issue_instr_i[20+:REG_W]);
    uop_in_s.rs1 = UOP_XLEN'(issue_rs1_i);
    uop_in_s.rs2 = UOP_XLEN'(issue_rs2_i);
    uop_in_s.m   = UOP_DIM_W'(m_r);
    uop_in_s.n   = UOP_DIM_W'(n_r);
    uop_in_s.k   = UOP_DIM_W'(k_r);
  end

  // Active M/N/K configuration, survives flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_r <= DIM_W'(MAX_DIM);
      n_r <= DIM_W'(MAX_DIM);
      k_r <= DIM_W'(MAX_DIM);
    end else if (mcfg_fire_s) begin
      m_r <= DIM_W'(clamp_dim(issue_rs1_i[7:0],   8'(MAX_DIM)));
      n_r <= DIM_W'(clamp_dim(issue_rs1_i[15:8],  8'(MAX_DIM)));
      k_r <= DIM_W'(clamp_dim(issue_rs1_i[23:16], 8'(MAX_DIM)));
    end
  end

  quadrilatero_fifo #(
    .DEPTH (DEPTH),
    .T     (uop_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush_i),
    .push      (push_s),
    .push_data (uop_in_s),
    .pop       (uop_ready_i),
    .head      (uop_o),
    .valid     (uop_valid_o),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign issue_ready_o  = ready_s;
  assign issue_accept_o = ready_s && legal_s;
  assign empty_o        = fifo_empty_s;
  assign cfg_o          = {k_r, n_r, m_r};

`ifdef QUADRILATERO_DECODE_PERF_EN
  logic [31:0] perf_acc_r, perf_ill_r, perf_stall_r;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_acc_r   <= 32'd0;
      perf_ill_r   <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (ready_s && legal_s && (perf_acc_r != 32'hFFFF_FFFF))  perf_acc_r <= perf_acc_r + 32'd1;
      if (ready_s && !legal_s && (perf_ill_r != 32'hFFFF_FFFF)) perf_ill_r <= perf_ill_r + 32'd1;
      if (issue_valid_i && !ready_s && (perf_stall_r != 32'hFFFF_FFFF))
        perf_stall_r <= perf_stall_r + 32'd1;
    end
  end

  assign perf_accepted_o = perf_acc_r;
  assign perf_illegal_o  = perf_ill_r;
  assign perf_stall_o    = perf_stall_r;
`endif

endmodule

// File: tb/tb_quadrilatero_decode_queue.sv
// Directed self-checking bench for quadrilatero_decode_queue (default parameters).
module tb_quadrilatero_decode_queue;
  import quadrilatero_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready, issue_accept;
  logic [31:0] issue_instr, issue_rs1, issue_rs2;
  logic        flush, uop_valid, uop_ready, empty;
  uop_t        uop;
  logic [8:0]  cfg;
`ifdef QUADRILATERO_DECODE_PERF_EN
  logic [31:0] perf_acc, perf_ill, perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  quadrilatero_decode_queue dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (issue_valid),
    .issue_ready_o  (issue_ready),
    .issue_instr_i  (issue_instr),
    .issue_rs1_i    (issue_rs1),
    .issue_rs2_i    (issue_rs2),
    .issue_accept_o (issue_accept),
    .flush_i        (flush),
    .uop_valid_o    (uop_valid),
    .uop_ready_i    (uop_ready),
    .uop_o          (uop),
    .cfg_o          (cfg),
    .empty_o        (empty)
`ifdef QUADRILATERO_DECODE_PERF_EN
    ,
    .perf_accepted_o (perf_acc),
    .perf_illegal_o  (perf_ill),
    .perf_stall_o    (perf_stall)
`endif
  );

  function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] sub,
                                      input logic [2:0] ew, input logic [4:0] md,
                                      input logic [4:0] ms1, input logic [4:0] ms2);
    return {f5, sub, ms2, ms1, ew, md, 7'b0101011};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_instr = 32'd0;
    issue_rs1   = 32'd0;
    issue_rs2   = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; uop_ready = 1'b0;
    idle();
    tick(); tick();
    chk("rst_valid", uop_valid, 1'b0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_ready", issue_ready, 1'b0);
    chk("rst_accept", issue_accept, 1'b0);
    chk("rst_cfg", cfg, {3'd4, 3'd4, 3'd4});
    rst_n = 1'b1;
    tick();

    // MLD word, md=3
    offer(enc(5'b00000, 2'b00, 3'b010, 5'd3, 5'd0, 5'd0), 32'h1000, 32'h40);
    chk("mld_ready", issue_ready, 1'b1);
    chk("mld_accept", issue_accept, 1'b1);
    chk("mld_not_yet", uop_valid, 1'b0);
    tick(); idle();
    chk("mld_valid", uop_valid, 1'b1);
    chk("mld_cls", uop.cls, UOP_MLD);
    chk("mld_md", uop.md, 5'd3);
    chk("mld_base", uop.rs1, 32'h1000);
    chk("mld_stride", uop.rs2, 32'h40);
    chk("mld_mnk", {uop.m, uop.n, uop.k}, {8'd4, 8'd4, 8'd4});
    uop_ready = 1'b1; tick(); uop_ready = 1'b0;
    chk("mld_drained", empty, 1'b1);

    // MCFG M=1 N=3 K=2
    offer(enc(5'b11111, 2'b11, 3'b010, 5'd0, 5'd0, 5'd0), 32'h0002_0301, 32'd0);
    chk("mcfg_ready", issue_ready, 1'b1);
    chk("mcfg_accept", issue_accept, 1'b1);
    tick(); idle();
    chk("mcfg_cfg", cfg, {3'd2, 3'd3, 3'd1});
    chk("mcfg_not_queued", empty, 1'b1);
    offer(enc(5'b00010, 2'b00, 3'b010, 5'd1, 5'd2, 5'd3), 32'd0, 32'd0);
    tick(); idle();
    chk("mmacf_cls", uop.cls, UOP_MMAC_F);
    chk("mmacf_mnk", {uop.m, uop.n, uop.k}, {8'd1, 8'd3, 8'd2});
    uop_ready = 1'b1; tick(); uop_ready = 1'b0;

    // MCFG clamp: M=N=0 -> 1, K=9 -> 4
    offer(enc(5'b11111, 2'b11, 3'b010, 5'd0, 5'd0, 5'd0), 32'h0009_0000, 32'd0);
    tick(); idle();
    chk("clamp_cfg", cfg, {3'd4, 3'd1, 3'd1});

    // Fill the queue, then a fifth offer must stall even with a pop
    for (int i = 0; i < 4; i++) begin
      offer(enc(5'b11111, 2'b00, 3'b000, 5'(i), 5'd0, 5'd0), 32'd0, 32'd0);
      chk("fill_ready", issue_ready, 1'b1);
      tick();
    end
    offer(enc(5'b11111, 2'b00, 3'b000, 5'd4, 5'd0, 5'd0), 32'd0, 32'd0);
    chk("full_stall", issue_ready, 1'b0);
    uop_ready = 1'b1; #1;
    chk("full_pop_stall", issue_ready, 1'b0);
    tick(); uop_ready = 1'b0; #1;
    chk("after_pop_ready", issue_ready, 1'b1);
    chk("after_pop_accept", issue_accept, 1'b1);
    tick(); idle();
    uop_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_md", uop.md, 5'(i));
      tick();
    end
    uop_ready = 1'b0;
    chk("drain_empty", empty, 1'b1);

    // Illegal encodings are consumed without queuing
    offer({25'd0, 7'b0110011}, 32'd0, 32'd0);
    chk("bad_opc_ready", issue_ready, 1'b1);
    chk("bad_opc_accept", issue_accept, 1'b0);
    tick();
    chk("bad_opc_empty", empty, 1'b1);
    offer(enc(5'b00000, 2'b00, 3'b011, 5'd1, 5'd0, 5'd0), 32'd0, 32'd0);
    chk("ew64_ready", issue_ready, 1'b1);
    chk("ew64_accept", issue_accept, 1'b0);
    tick();
    offer(enc(5'b00010, 2'b00, 3'b010, 5'd1, 5'd9, 5'd2), 32'd0, 32'd0);
    chk("ms1_ready", issue_ready, 1'b1);
    chk("ms1_accept", issue_accept, 1'b0);
    tick();
    offer(enc(5'b11111, 2'b01, 3'b010, 5'd0, 5'd0, 5'd0), 32'd0, 32'd0);
    chk("misc01_accept", issue_accept, 1'b0);
    offer(enc(5'b00100, 2'b00, 3'b010, 5'd0, 5'd0, 5'd0), 32'd0, 32'd0);
    chk("f5_bad_accept", issue_accept, 1'b0);
    offer(enc(5'b11110, 2'b00, 3'b100, 5'd0, 5'd0, 5'd0), 32'd0, 32'd0);
    chk("ew100_accept", issue_accept, 1'b0);
    tick(); idle();
    chk("illegal_empty", empty, 1'b1);

    // MCFG waits for two queued ops to drain; they keep the old config
    offer(enc(5'b00000, 2'b00, 3'b010, 5'd1, 5'd0, 5'd0), 32'd0, 32'd0);
    tick();
    offer(enc(5'b00001, 2'b00, 3'b010, 5'd2, 5'd0, 5'd0), 32'd0, 32'd0);
    tick();
    offer(enc(5'b11111, 2'b11, 3'b010, 5'd0, 5'd0, 5'd0), 32'h0003_0201, 32'd0);
    chk("mcfg_wait0", issue_ready, 1'b0);
    tick();
    chk("mcfg_wait1", issue_ready, 1'b0);
    uop_ready = 1'b1;
    chk("old_cfg_md1", uop.md, 5'd1);
    chk("old_cfg_mnk1", {uop.m, uop.n, uop.k}, {8'd1, 8'd1, 8'd4});
    tick();
    chk("mcfg_wait2", issue_ready, 1'b0);
    chk("old_cfg_cls2", uop.cls, UOP_MST);
    chk("old_cfg_mnk2", {uop.m, uop.n, uop.k}, {8'd1, 8'd1, 8'd4});
    tick();
    chk("mcfg_go_ready", issue_ready, 1'b1);
    chk("mcfg_go_accept", issue_accept, 1'b1);
    uop_ready = 1'b0;
    tick(); idle();
    chk("mcfg_applied", cfg, {3'd3, 3'd2, 3'd1});

    // Flush with 3 entries plus simultaneous push and pop
    for (int i = 5; i < 8; i++) begin
      offer(enc(5'b11111, 2'b00, 3'b001, 5'(i), 5'd0, 5'd0), 32'd0, 32'd0);
      tick();
    end
    offer(enc(5'b11110, 2'b00, 3'b010, 5'd1, 5'd2, 5'd3), 32'd0, 32'd0);
    flush = 1'b1; uop_ready = 1'b1; #1;
    chk("flush_ready", issue_ready, 1'b0);
    chk("flush_accept", issue_accept, 1'b0);
    tick();
    flush = 1'b0; uop_ready = 1'b0; idle();
    chk("flush_empty", empty, 1'b1);
    chk("flush_valid", uop_valid, 1'b0);
    chk("flush_cfg_kept", cfg, {3'd3, 3'd2, 3'd1});
    offer(enc(5'b00000, 2'b00, 3'b010, 5'd2, 5'd0, 5'd0), 32'hABC, 32'd8);
    tick(); idle();
    chk("post_flush_valid", uop_valid, 1'b1);
    chk("post_flush_rs1", uop.rs1, 32'hABC);
    chk("post_flush_mnk", {uop.m, uop.n, uop.k}, {8'd1, 8'd2, 8'd3});

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0; #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_valid", uop_valid, 1'b0);
    chk("arst_cfg", cfg, {3'd4, 3'd4, 3'd4});
    tick();
    rst_n = 1'b1;
    tick();

`ifdef QUADRILATERO_DECODE_PERF_EN
    chk("perf_rst_acc", perf_acc, 32'd0);
    chk("perf_rst_ill", perf_ill, 32'd0);
    chk("perf_rst_stall", perf_stall, 32'd0);
    offer({25'd0, 7'b0110011}, 32'd0, 32'd0);
    tick();
    offer(enc(5'b11111, 2'b11, 3'b010, 5'd0, 5'd0, 5'd0), 32'h0001_0101, 32'd0);
    tick();
    offer(enc(5'b00000, 2'b00, 3'b010, 5'd1, 5'd0, 5'd0), 32'd0, 32'd0);
    flush = 1'b1;
    tick(); tick();
    flush = 1'b0; idle();
    #1;
    chk("perf_acc", perf_acc, 32'd1);
    chk("perf_ill", perf_ill, 32'd1);
    chk("perf_stall", perf_stall, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
